// File: rtl/fetch_sequencer.sv
// Program-counter and fetch sequencing: PC register, writable branch-target LUT,
// halt detection, start/stall control, sticky done/miss flags and saturating counters.
module fetch_sequencer #(
   parameter int PC_W       = 12,
   parameter int LBL_W      = 8,
   parameter int LUT_DEPTH  = 16,
   parameter int START_ADDR = 0,
   parameter int HALT_ADDR  = 650,
   parameter int CNT_W      = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic                         stall,
   input  logic                         branch_taken,
   input  logic [LBL_W-1:0]             branch_label,
   input  logic                         lut_we,
   input  logic [$clog2(LUT_DEPTH)-1:0] lut_waddr,
   input  logic [PC_W-1:0]              lut_wdata,
   output logic [PC_W-1:0]              pc,
   output logic [PC_W-1:0]              pc_plus1,
   output logic                         done,
   output logic                         lut_miss,
   output logic [CNT_W-1:0]             cycle_count,
   output logic [CNT_W-1:0]             instr_count,
   output logic [1:0]                   fsm_state
);

   localparam int IDX_W  = $clog2(LUT_DEPTH);
   localparam int LBL_CW = LBL_W + 1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_HALTED = 2'd2;

   localparam logic [PC_W-1:0]   START_PC  = PC_W'(START_ADDR);
   localparam logic [PC_W-1:0]   HALT_PC   = PC_W'(HALT_ADDR);
   localparam logic [LBL_CW-1:0] DEPTH_LBL = LBL_CW'(LUT_DEPTH);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   logic [1:0]      state;
   logic [1:0]      state_nxt;
   logic [PC_W-1:0] pc_nxt;
   logic [PC_W-1:0] lut [LUT_DEPTH];
   logic            running;
   logic            advance;
   logic            at_halt;
   logic            lut_hit;
   logic            miss_now;

   assign fsm_state = state;
   assign pc_plus1  = pc + PC_W'(1);
   assign running   = (state == ST_RUN);
   assign advance   = running && !stall;
   assign at_halt   = (pc == HALT_PC);
   assign lut_hit   = branch_taken && ({1'b0, branch_label} < DEPTH_LBL);
   assign miss_now  = advance && !at_halt && branch_taken && !lut_hit;

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      case (state)
         ST_IDLE: begin
            if (start) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (!stall) begin
               if (at_halt)      state_nxt = ST_HALTED;
               else if (lut_hit) pc_nxt    = lut[branch_label[IDX_W-1:0]];
               else              pc_nxt    = pc_plus1;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         pc          <= START_PC;
         done        <= 1'b0;
         lut_miss    <= 1'b0;
         cycle_count <= '0;
         instr_count <= '0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         // HALTED is terminal, so done simply mirrors the registered next state.
         done  <= (state_nxt == ST_HALTED);
         if (miss_now) lut_miss <= 1'b1;
         if (running && (cycle_count != CNT_MAX)) cycle_count <= cycle_count + CNT_W'(1);
         if (advance && (instr_count != CNT_MAX)) instr_count <= instr_count + CNT_W'(1);
      end
   end

   // Non-blocking write gives read-before-write for a same-cycle taken branch.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < LUT_DEPTH; i++) lut[i] <= '0;
      end else if (lut_we) begin
         lut[lut_waddr] <= lut_wdata;
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized
// traffic compared against a rule-level reference model.
module tb_fetch_sequencer;

   localparam int PC_W    = 12;
   localparam int DEPTH   = 16;
   localparam int HALT    = 650;
   localparam int CNT_W   = 10;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
   localparam int PC_MOD  = 1 << PC_W;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              stall;
   logic              branch_taken;
   logic [7:0]        branch_label;
   logic              lut_we;
   logic [3:0]        lut_waddr;
   logic [PC_W-1:0]   lut_wdata;
   logic [PC_W-1:0]   pc;
   logic [PC_W-1:0]   pc_plus1;
   logic              done;
   logic              lut_miss;
   logic [CNT_W-1:0]  cycle_count;
   logic [CNT_W-1:0]  instr_count;
   logic [1:0]        fsm_state;

   int total = 0;
   int bad   = 0;

   // reference model state
   int m_state;   // 0 idle, 1 run, 2 halted
   int m_pc;
   int m_lut [DEPTH];
   int m_done;
   int m_miss;
   int m_cyc;
   int m_ins;

   fetch_sequencer #(
      .PC_W(PC_W), .LBL_W(8), .LUT_DEPTH(DEPTH),
      .START_ADDR(0), .HALT_ADDR(HALT), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .stall(stall),
      .branch_taken(branch_taken), .branch_label(branch_label),
      .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
      .pc(pc), .pc_plus1(pc_plus1), .done(done), .lut_miss(lut_miss),
      .cycle_count(cycle_count), .instr_count(instr_count), .fsm_state(fsm_state)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_state = 0; m_pc = 0; m_done = 0; m_miss = 0; m_cyc = 0; m_ins = 0;
      for (int i = 0; i < DEPTH; i++) m_lut[i] = 0;
   endtask

   task automatic model_edge();
      if (!reset) begin
         model_reset();
         return;
      end
      if (m_state == 0) begin
         if (start) m_state = 1;
      end else if (m_state == 1) begin
         if (m_cyc < CNT_MAX) m_cyc++;
         if (!stall) begin
            if (m_ins < CNT_MAX) m_ins++;
            if (m_pc == HALT) begin
               m_state = 2;
               m_done  = 1;
            end else if (branch_taken && int'(branch_label) < DEPTH) begin
               m_pc = m_lut[branch_label];
            end else begin
               if (branch_taken) m_miss = 1;
               m_pc = (m_pc + 1) % PC_MOD;
            end
         end
      end
      if (lut_we) m_lut[lut_waddr] = int'(lut_wdata);
   endtask

   task automatic drive(input logic st, input logic stl, input logic br, input logic [7:0] lbl,
                        input logic we, input logic [3:0] wa, input logic [PC_W-1:0] wd);
      start = st; stall = stl; branch_taken = br; branch_label = lbl;
      lut_we = we; lut_waddr = wa; lut_wdata = wd;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      drive(0, 0, 0, 8'd0, 0, 4'd0, '0);
      drive(0, 0, 0, 8'd0, 0, 4'd0, '0);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      start = 0; stall = 0; branch_taken = 0; branch_label = 0;
      lut_we = 0; lut_waddr = 0; lut_wdata = 0;
      #1;
      model_reset();
      total++;
      if (pc !== 12'd0 || done !== 1'b0 || lut_miss !== 1'b0 || cycle_count !== 10'd0 || instr_count !== 10'd0) begin
         bad++;
         $display("FAIL reset_values: pc=%0h done=%0b miss=%0b cyc=%0d ins=%0d exp all zero",
                  pc, done, lut_miss, cycle_count, instr_count);
      end
      apply_reset();
      for (int i = 0; i < 10; i++) begin
         drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 20)), 0, 4'd0, '0);
         total++;
         if (pc !== 12'd0 || done !== 1'b0 || cycle_count !== 10'd0 || instr_count !== 10'd0) begin
            bad++;
            $display("FAIL idle_hold[%0d]: pc=%0h done=%0b cyc=%0d ins=%0d exp 0/0/0/0",
                     i, pc, done, cycle_count, instr_count);
         end
      end
   endtask

   task automatic test_lut_branch();
      apply_reset();
      drive(0, 0, 0, 8'd0, 1, 4'd3, 12'h040);
      drive(0, 0, 0, 8'd0, 1, 4'd0, 12'h005);
      drive(1, 0, 0, 8'd0, 0, 4'd0, '0);
      drive(0, 0, 1, 8'd0, 0, 4'd0, '0);
      total++;
      if (pc !== 12'h005) begin bad++; $display("FAIL branch_to_5: pc=%0h exp 5", pc); end
      drive(0, 0, 1, 8'd3, 0, 4'd0, '0);
      total++;
      if (pc !== 12'h040 || lut_miss !== 1'b0) begin
         bad++; $display("FAIL branch_hit: pc=%0h miss=%0b exp 40/0", pc, lut_miss);
      end
      drive(0, 0, 1, 8'd0, 0, 4'd0, '0);
      drive(0, 0, 1, 8'd20, 0, 4'd0, '0);
      total++;
      if (pc !== 12'h006 || lut_miss !== 1'b1) begin
         bad++; $display("FAIL branch_miss: pc=%0h miss=%0b exp 6/1", pc, lut_miss);
      end
      total++;
      if (instr_count !== 10'd4 || cycle_count !== 10'd4) begin
         bad++; $display("FAIL branch_counts: ins=%0d cyc=%0d exp 4/4", instr_count, cycle_count);
      end
   endtask

   task automatic test_stall();
      logic [CNT_W-1:0] c0, i0;
      for (int i = 0; i < 4; i++) drive(0, 0, 0, 8'd0, 0, 4'd0, '0);
      total++;
      if (pc !== 12'd10) begin bad++; $display("FAIL stall_setup: pc=%0h exp a", pc); end
      c0 = cycle_count; i0 = instr_count;
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, 1, 8'd3, 0, 4'd0, '0);
         total++;
         if (pc !== 12'd10) begin bad++; $display("FAIL stall_hold[%0d]: pc=%0h exp a", i, pc); end
      end
      total++;
      if (cycle_count !== c0 + 10'd4 || instr_count !== i0) begin
         bad++; $display("FAIL stall_counts: cyc=%0d ins=%0d exp %0d/%0d", cycle_count, instr_count, c0 + 10'd4, i0);
      end
      drive(0, 0, 0, 8'd0, 0, 4'd0, '0);
      total++;
      if (pc !== 12'd11) begin bad++; $display("FAIL stall_release: pc=%0h exp b", pc); end
   endtask

   task automatic test_rbw_wrap();
      drive(0, 0, 0, 8'd0, 1, 4'd2, 12'h080);
      drive(0, 0, 1, 8'd2, 1, 4'd2, 12'h100);
      total++;
      if (pc !== 12'h080) begin bad++; $display("FAIL rbw_old: pc=%0h exp 80", pc); end
      drive(0, 0, 1, 8'd2, 1, 4'd5, 12'hFFF);
      total++;
      if (pc !== 12'h100) begin bad++; $display("FAIL rbw_new: pc=%0h exp 100", pc); end
      drive(0, 0, 1, 8'd5, 0, 4'd0, '0);
      total++;
      if (pc !== 12'hFFF || pc_plus1 !== 12'h000) begin
         bad++; $display("FAIL wrap_top: pc=%0h pc_plus1=%0h exp fff/0", pc, pc_plus1);
      end
      drive(0, 0, 0, 8'd0, 0, 4'd0, '0);
      total++;
      if (pc !== 12'h000) begin bad++; $display("FAIL wrap_zero: pc=%0h exp 0", pc); end
   endtask

   task automatic test_saturate();
      int i0;
      i0 = m_ins;
      for (int i = 0; i < CNT_MAX + 10; i++) drive(0, 1, 0, 8'd0, 0, 4'd0, '0);
      total++;
      if (cycle_count !== 10'h3FF || instr_count !== m_ins[CNT_W-1:0] || m_ins != i0) begin
         bad++; $display("FAIL saturate: cyc=%0d ins=%0d exp 1023/%0d", cycle_count, instr_count, i0);
      end
   endtask

   task automatic test_straight();
      apply_reset();
      drive(1, 0, 0, 8'd0, 0, 4'd0, '0);
      for (int i = 0; i < HALT + 1; i++) begin
         total++;
         if (pc !== m_pc[PC_W-1:0] || done !== 1'b0) begin
            bad++; $display("FAIL straight_pc[%0d]: pc=%0h done=%0b exp %0h/0", i, pc, done, m_pc);
         end
         drive(0, 0, 0, 8'd0, 0, 4'd0, '0);
      end
      total++;
      if (pc !== 12'd650 || done !== 1'b1 || instr_count !== 10'd651 || m_ins != 651) begin
         bad++; $display("FAIL halt_state: pc=%0d done=%0b ins=%0d exp 650/1/651", pc, done, instr_count);
      end
      for (int i = 0; i < 5; i++) begin
         drive(1, 0, 1, 8'd0, 0, 4'd0, '0);
         total++;
         if (pc !== 12'd650 || done !== 1'b1 || instr_count !== 10'd651 || cycle_count !== m_cyc[CNT_W-1:0]) begin
            bad++; $display("FAIL halted_frozen[%0d]: pc=%0d done=%0b ins=%0d cyc=%0d exp 650/1/651/%0d",
                            i, pc, done, instr_count, cycle_count, m_cyc);
         end
      end
   endtask

   task automatic test_midreset();
      apply_reset();
      drive(0, 0, 0, 8'd0, 1, 4'd3, 12'h040);
      drive(1, 0, 0, 8'd0, 0, 4'd0, '0);
      for (int i = 0; i < 300; i++) drive(0, 0, 0, 8'd0, 0, 4'd0, '0);
      total++;
      if (pc !== 12'd300) begin bad++; $display("FAIL midreset_setup: pc=%0d exp 300", pc); end
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      total++;
      if (pc !== 12'd0 || done !== 1'b0 || cycle_count !== 10'd0 || instr_count !== 10'd0) begin
         bad++; $display("FAIL midreset_async: pc=%0d done=%0b cyc=%0d ins=%0d exp 0", pc, done, cycle_count, instr_count);
      end
      drive(0, 0, 0, 8'd0, 0, 4'd0, '0);
      reset = 1'b1;
      drive(0, 0, 0, 8'd0, 0, 4'd0, '0);
      drive(0, 0, 0, 8'd0, 0, 4'd0, '0);
      total++;
      if (pc !== 12'd0 || cycle_count !== 10'd0) begin
         bad++; $display("FAIL midreset_idle: pc=%0d cyc=%0d exp 0/0", pc, cycle_count);
      end
      drive(1, 0, 0, 8'd0, 0, 4'd0, '0);
      drive(0, 0, 0, 8'd0, 0, 4'd0, '0);
      drive(0, 0, 1, 8'd3, 0, 4'd0, '0);
      total++;
      if (pc !== 12'd0) begin bad++; $display("FAIL midreset_lut_cleared: pc=%0h exp 0", pc); end
   endtask

   task automatic test_random();
      apply_reset();
      for (int i = 0; i < DEPTH; i++)
         drive(0, 0, 0, 8'd0, 1, 4'(i), 12'($urandom_range(0, PC_MOD - 1)));
      drive(1, 0, 0, 8'd0, 0, 4'd0, '0);
      for (int i = 0; i < 1500; i++) begin
         drive(1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 9) < 3),
               ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, DEPTH - 1)),
               ($urandom_range(0, 4) == 0),
               4'($urandom_range(0, DEPTH - 1)),
               12'($urandom_range(0, PC_MOD - 1)));
         total++;
         if (pc !== m_pc[PC_W-1:0] || pc_plus1 !== 12'((m_pc + 1) % PC_MOD) ||
             done !== 1'(m_done) || lut_miss !== 1'(m_miss) ||
             cycle_count !== m_cyc[CNT_W-1:0] || instr_count !== m_ins[CNT_W-1:0]) begin
            bad++;
            $display("FAIL random[%0d]: pc=%0h p1=%0h done=%0b miss=%0b cyc=%0d ins=%0d exp %0h/%0h/%0d/%0d/%0d/%0d",
                     i, pc, pc_plus1, done, lut_miss, cycle_count, instr_count,
                     m_pc, (m_pc + 1) % PC_MOD, m_done, m_miss, m_cyc, m_ins);
         end
      end
   endtask

   initial begin
      test_reset();
      test_lut_branch();
      test_stall();
      test_rbw_wrap();
      test_saturate();
      test_straight();
      test_midreset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
